// File: rtl/pe_pkg.sv
// Shared defaults and FSM state type for the PE operand feeder.
package pe_pkg;

  localparam int unsigned DefDataInWidth = 8;
  localparam int unsigned DefBufferWidth = 2;
  localparam int unsigned DefBufferSize  = 4;
  localparam int unsigned DefLenWidth    = 8;
  localparam int unsigned StatWidth      = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pe_feeder_if.sv
// Host-side triple input and the three W/I/O operand output channels.
interface pe_feeder_if #(
  parameter int unsigned DataInWidth = pe_pkg::DefDataInWidth
) ();

  logic                   Host_DataInValid;
  logic                   Host_DataInRdy;
  logic [DataInWidth-1:0] Host_W;
  logic [DataInWidth-1:0] Host_I;
  logic [DataInWidth-1:0] Host_O;

  logic [DataInWidth-1:0] W_DataOut;
  logic                   W_DataOutValid;
  logic                   W_DataOutRdy;

  logic [DataInWidth-1:0] I_DataOut;
  logic                   I_DataOutValid;
  logic                   I_DataOutRdy;

  logic [DataInWidth-1:0] O_DataOut;
  logic                   O_NOPOut;
  logic                   O_DataOutRdy;

  // master: host and PE array side
  modport master (
    output Host_DataInValid, Host_W, Host_I, Host_O,
    output W_DataOutRdy, I_DataOutRdy, O_DataOutRdy,
    input  Host_DataInRdy,
    input  W_DataOut, W_DataOutValid,
    input  I_DataOut, I_DataOutValid,
    input  O_DataOut, O_NOPOut
  );

  // slave: the feeder itself
  modport slave (
    input  Host_DataInValid, Host_W, Host_I, Host_O,
    input  W_DataOutRdy, I_DataOutRdy, O_DataOutRdy,
    output Host_DataInRdy,
    output W_DataOut, W_DataOutValid,
    output I_DataOut, I_DataOutValid,
    output O_DataOut, O_NOPOut
  );

endinterface

// File: rtl/feeder_channel.sv
// One output channel: private head pointer, valid decode and sent-item count.
module feeder_channel #(
  parameter int unsigned BufferWidth = pe_pkg::DefBufferWidth,
  parameter int unsigned LenWidth    = pe_pkg::DefLenWidth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   run,
  input  logic [BufferWidth:0]   tail,
  input  logic                   rdy,
  input  logic [LenWidth-1:0]    len,
  output logic                   valid_c,
  output logic                   fire_c,
  output logic                   last_c,
  output logic [BufferWidth:0]   head
);

  localparam int unsigned PtrWidth = BufferWidth + 1;

  logic [PtrWidth-1:0] head_q;
  logic [LenWidth-1:0] sent_q;
  logic [LenWidth-1:0] sent_next_c;

  assign valid_c     = run && (head_q != tail);
  assign fire_c      = valid_c && rdy;
  assign sent_next_c = fire_c ? sent_q + LenWidth'(1) : sent_q;
  // High once this channel has delivered the whole job, counting this cycle's beat
  assign last_c      = (sent_next_c == len);
  assign head        = head_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      sent_q <= '0;
    end else if (clear) begin
      head_q <= '0;
      sent_q <= '0;
    end else if (fire_c) begin
      head_q <= head_q + PtrWidth'(1);
      sent_q <= sent_q + LenWidth'(1);
    end
  end

endmodule

// File: rtl/pe_feeder.sv
// Buffers host operand triples and fans them out to independent W/I/O channels.
// Optional FEEDER_STATS_EN adds a saturating Stall_Count output.
module pe_feeder
  import pe_pkg::*;
#(
  parameter int unsigned DataInWidth = DefDataInWidth,
  parameter int unsigned BufferWidth = DefBufferWidth,
  parameter int unsigned BufferSize  = DefBufferSize,
  parameter int unsigned LenWidth    = DefLenWidth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Start,
  input  logic [LenWidth-1:0]  Len,
  output logic                 Busy,
  output logic                 Done,
`ifdef FEEDER_STATS_EN
  output logic [StatWidth-1:0] Stall_Count,
`endif
  pe_feeder_if.slave           bus
);

  localparam int unsigned PtrWidth = BufferWidth + 1;

  state_e state_q;
  state_e state_d;

  logic [LenWidth-1:0]    len_q;
  logic [LenWidth-1:0]    acc_q;
  logic [PtrWidth-1:0]    tail_q;

  logic [DataInWidth-1:0] buf_w [BufferSize];
  logic [DataInWidth-1:0] buf_i [BufferSize];
  logic [DataInWidth-1:0] buf_o [BufferSize];

  logic start_acc_c;
  logic run_c;
  logic host_rdy_c;
  logic host_fire_c;
  logic full_c;
  logic all_done_c;

  logic                w_valid_c, i_valid_c, o_valid_c;
  logic                w_fire_c,  i_fire_c,  o_fire_c;
  logic                w_last_c,  i_last_c,  o_last_c;
  logic [PtrWidth-1:0] head_w, head_i, head_o;
  logic [PtrWidth-1:0] occ_w_c, occ_i_c, occ_o_c, occ_max_c;

  assign start_acc_c = (state_q == ST_IDLE) && Start;
  assign run_c       = (state_q == ST_RUN);
  assign all_done_c  = w_last_c && i_last_c && o_last_c;

  assign Busy = run_c;
  assign Done = (state_q == ST_DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (Start) state_d = (Len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (all_done_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Occupancy is measured against the slowest channel; an entry is only reusable
  // once every head has moved past it.
  always_comb begin
    occ_w_c   = tail_q - head_w;
    occ_i_c   = tail_q - head_i;
    occ_o_c   = tail_q - head_o;
    occ_max_c = occ_w_c;
    if (occ_i_c > occ_max_c) occ_max_c = occ_i_c;
    if (occ_o_c > occ_max_c) occ_max_c = occ_o_c;
  end

  assign full_c      = (occ_max_c == PtrWidth'(BufferSize));
  assign host_rdy_c  = run_c && !full_c && (acc_q < len_q);
  assign host_fire_c = host_rdy_c && bus.Host_DataInValid;

  // Job length latch, accepted-triple count and tail pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q  <= '0;
      acc_q  <= '0;
      tail_q <= '0;
    end else if (start_acc_c) begin
      len_q  <= Len;
      acc_q  <= '0;
      tail_q <= '0;
    end else if (host_fire_c) begin
      acc_q  <= acc_q + LenWidth'(1);
      tail_q <= tail_q + PtrWidth'(1);
    end
  end

  // Triple storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (host_fire_c) begin
      buf_w[tail_q[BufferWidth-1:0]] <= bus.Host_W;
      buf_i[tail_q[BufferWidth-1:0]] <= bus.Host_I;
      buf_o[tail_q[BufferWidth-1:0]] <= bus.Host_O;
    end
  end

  feeder_channel #(.BufferWidth(BufferWidth), .LenWidth(LenWidth)) u_ch_w (
    .clk(clk), .rst(rst), .clear(start_acc_c), .run(run_c), .tail(tail_q),
    .rdy(bus.W_DataOutRdy), .len(len_q),
    .valid_c(w_valid_c), .fire_c(w_fire_c), .last_c(w_last_c), .head(head_w)
  );

  feeder_channel #(.BufferWidth(BufferWidth), .LenWidth(LenWidth)) u_ch_i (
    .clk(clk), .rst(rst), .clear(start_acc_c), .run(run_c), .tail(tail_q),
    .rdy(bus.I_DataOutRdy), .len(len_q),
    .valid_c(i_valid_c), .fire_c(i_fire_c), .last_c(i_last_c), .head(head_i)
  );

  feeder_channel #(.BufferWidth(BufferWidth), .LenWidth(LenWidth)) u_ch_o (
    .clk(clk), .rst(rst), .clear(start_acc_c), .run(run_c), .tail(tail_q),
    .rdy(bus.O_DataOutRdy), .len(len_q),
    .valid_c(o_valid_c), .fire_c(o_fire_c), .last_c(o_last_c), .head(head_o)
  );

  assign bus.Host_DataInRdy = host_rdy_c;
  assign bus.W_DataOutValid = w_valid_c;
  assign bus.I_DataOutValid = i_valid_c;
  assign bus.O_NOPOut       = o_valid_c;
  assign bus.W_DataOut      = buf_w[head_w[BufferWidth-1:0]];
  assign bus.I_DataOut      = buf_i[head_i[BufferWidth-1:0]];
  assign bus.O_DataOut      = buf_o[head_o[BufferWidth-1:0]];

`ifdef FEEDER_STATS_EN
  logic [StatWidth-1:0] stall_q;
  logic                 stall_c;

  assign stall_c = run_c && ((w_valid_c && !bus.W_DataOutRdy) ||
                             (i_valid_c && !bus.I_DataOutRdy) ||
                             (o_valid_c && !bus.O_DataOutRdy));

  // Saturating back-pressure cycle counter, restarted by each accepted job
  always_ff @(posedge clk) begin
    if (rst)                           stall_q <= '0;
    else if (start_acc_c)              stall_q <= '0;
    else if (stall_c && stall_q != '1) stall_q <= stall_q + StatWidth'(1);
  end

  assign Stall_Count = stall_q;
`endif

endmodule

// File: tb/tb_pe_feeder.sv
// Scoreboard bench for pe_feeder: job table plus reset-mid-job sequence.
module tb_pe_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       Start;
  logic [7:0] Len;
  logic       Busy;
  logic       Done;
`ifdef FEEDER_STATS_EN
  logic [15:0] Stall_Count;
`endif

  always #5 clk = ~clk;

  pe_feeder_if #(.DataInWidth(8)) bus ();

  pe_feeder #(.DataInWidth(8), .BufferWidth(2), .BufferSize(4), .LenWidth(8)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Len(Len), .Busy(Busy), .Done(Done),
`ifdef FEEDER_STATS_EN
    .Stall_Count(Stall_Count),
`endif
    .bus(bus)
  );

  typedef struct {
    int len;
    int rnd_w; int rnd_i; int rnd_o;
    int w_hold; int o_hold;
    int exp_lat; int exp_span; int exp_hs_w; int exp_done_lat; int exp_stall;
  } vec_t;

  vec_t vecs [8];

  logic [7:0] q_w [$];
  logic [7:0] q_i [$];
  logic [7:0] q_o [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0, done_cyc = -1, start_cyc = -1;
  int n_w = 0, n_i = 0, n_o = 0, viol = 0, hs_cnt = 0;
  int first_hs = -1, first_wv = -1, first_wf = -1, last_wf = -1;
  int hs_at_w = -1, i_at_w = -1, o_at_w = -1, rdy_at_w = -1;
  int rnd_w = 0, rnd_i = 0, rnd_o = 0, w_hold = 0, o_hold = 0;
  logic       pend_w = 1'b0, pend_i = 1'b0, pend_o = 1'b0;
  logic [7:0] pd_w = '0, pd_i = '0, pd_o = '0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_check(string name, int act, inout logic [7:0] q [$]);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d expected no output (scoreboard empty)", name, act);
    end else begin
      check(name, act, int'(q.pop_front()));
    end
  endtask

  // Ready drivers: W hold counts absolute cycles, O hold counts only cycles with O valid
  initial begin
    bus.W_DataOutRdy = 1'b0;
    bus.I_DataOutRdy = 1'b0;
    bus.O_DataOutRdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (w_hold > 0) begin
        bus.W_DataOutRdy = 1'b0;
        w_hold--;
      end else begin
        bus.W_DataOutRdy = (rnd_w != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      bus.I_DataOutRdy = (rnd_i != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_hold > 0 && bus.O_NOPOut) begin
        bus.O_DataOutRdy = 1'b0;
        o_hold--;
      end else begin
        bus.O_DataOutRdy = (rnd_o != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor and scoreboard, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.W_DataOutValid && bus.W_DataOutRdy && n_w == 0) begin
        hs_at_w  = hs_cnt;
        i_at_w   = n_i;
        o_at_w   = n_o;
        rdy_at_w = int'(bus.Host_DataInRdy);
      end
      if (bus.Host_DataInValid && bus.Host_DataInRdy) begin
        q_w.push_back(bus.Host_W);
        q_i.push_back(bus.Host_I);
        q_o.push_back(bus.Host_O);
        if (first_hs < 0) first_hs = cyc;
        hs_cnt++;
      end
      if (bus.W_DataOutValid && first_wv < 0) first_wv = cyc;
      if (bus.W_DataOutValid && bus.W_DataOutRdy) begin
        pop_check("w_data", int'(bus.W_DataOut), q_w);
        if (first_wf < 0) first_wf = cyc;
        last_wf = cyc;
        n_w++;
      end
      if (bus.I_DataOutValid && bus.I_DataOutRdy) begin
        pop_check("i_data", int'(bus.I_DataOut), q_i);
        n_i++;
      end
      if (bus.O_NOPOut && bus.O_DataOutRdy) begin
        pop_check("o_data", int'(bus.O_DataOut), q_o);
        n_o++;
      end
      if (!Busy && (bus.W_DataOutValid || bus.I_DataOutValid || bus.O_NOPOut || bus.Host_DataInRdy))
        viol++;
      if (pend_w && !(bus.W_DataOutValid && bus.W_DataOut == pd_w)) viol++;
      if (pend_i && !(bus.I_DataOutValid && bus.I_DataOut == pd_i)) viol++;
      if (pend_o && !(bus.O_NOPOut && bus.O_DataOut == pd_o)) viol++;
      pend_w = !rst && bus.W_DataOutValid && !bus.W_DataOutRdy;
      pend_i = !rst && bus.I_DataOutValid && !bus.I_DataOutRdy;
      pend_o = !rst && bus.O_NOPOut && !bus.O_DataOutRdy;
      pd_w = bus.W_DataOut;
      pd_i = bus.I_DataOut;
      pd_o = bus.O_DataOut;
      if (Done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_stats();
    done_cnt = 0; done_cyc = -1;
    n_w = 0; n_i = 0; n_o = 0; viol = 0; hs_cnt = 0;
    first_hs = -1; first_wv = -1; first_wf = -1; last_wf = -1;
    hs_at_w = -1; i_at_w = -1; o_at_w = -1; rdy_at_w = -1;
  endtask

  task automatic feed(int n, int base);
    for (int k = 0; k < n; k++) begin
      bit got;
      bus.Host_W = 8'(base + 3 * k + 1);
      bus.Host_I = 8'(base + 3 * k + 2);
      bus.Host_O = 8'(base + 3 * k + 3);
      bus.Host_DataInValid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 500 && !got; t++) begin
        @(negedge clk);
        got = bus.Host_DataInRdy;
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL feed_timeout: item %0d of %0d never accepted", k, n);
        bus.Host_DataInValid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    bus.Host_DataInValid = 1'b0;
  endtask

  task automatic run_job(vec_t v, int base);
    @(posedge clk);
    #1;
    rnd_w = v.rnd_w; rnd_i = v.rnd_i; rnd_o = v.rnd_o;
    w_hold = v.w_hold; o_hold = v.o_hold;
    clear_stats();
    Len = 8'(v.len);
    Start = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    feed(v.len, base);
    for (int t = 0; t < 3000 && done_cnt == 0; t++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("w_count", n_w, v.len);
    check("i_count", n_i, v.len);
    check("o_count", n_o, v.len);
    check("left_over", q_w.size() + q_i.size() + q_o.size(), 0);
    check("protocol_viol", viol, 0);
    check("busy_after", int'(Busy), 0);
    if (v.exp_lat >= 0) check("first_latency", first_wv - first_hs, v.exp_lat);
    if (v.exp_span >= 0) check("w_span", last_wf - first_wf, v.exp_span);
    if (v.exp_hs_w >= 0) begin
      check("accepts_while_w_stalled", hs_at_w, v.exp_hs_w);
      check("i_items_while_w_stalled", i_at_w, v.exp_hs_w);
      check("o_items_while_w_stalled", o_at_w, v.exp_hs_w);
      check("host_rdy_when_full", rdy_at_w, 0);
    end
    if (v.exp_done_lat >= 0) check("done_latency", done_cyc - start_cyc, v.exp_done_lat);
`ifdef FEEDER_STATS_EN
    if (v.exp_stall >= 0) check("stall_count", int'(Stall_Count), v.exp_stall);
`endif
  endtask

  initial begin
    //          len rw ri ro whld ohld lat span hsw dlat stall
    vecs[0] = '{3,  0, 0, 0, 0,   0,   1,  2,  -1, -1,  0};
    vecs[1] = '{6,  0, 0, 0, 10,  0,  -1, -1,   4, -1, -1};
    vecs[2] = '{0,  0, 0, 0, 0,   0,  -1, -1,  -1,  1,  0};
    vecs[3] = '{8,  1, 1, 1, 0,   0,  -1, -1,  -1, -1, -1};
    vecs[4] = '{8,  1, 0, 1, 0,   0,  -1, -1,  -1, -1, -1};
    vecs[5] = '{13, 0, 1, 1, 3,   0,  -1, -1,  -1, -1, -1};
    vecs[6] = '{2,  0, 0, 0, 0,   5,  -1, -1,  -1, -1,  5};
    vecs[7] = '{1,  0, 0, 0, 0,   0,   1,  0,  -1, -1,  0};

    rst = 1'b1;
    Start = 1'b0;
    Len = '0;
    bus.Host_DataInValid = 1'b0;
    bus.Host_W = '0;
    bus.Host_I = '0;
    bus.Host_O = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", int'(Busy), 0);
    check("reset_done", int'(Done), 0);
    check("reset_valids", int'({bus.W_DataOutValid, bus.I_DataOutValid, bus.O_NOPOut}), 0);
    check("reset_host_rdy", int'(bus.Host_DataInRdy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int j = 0; j < 8; j++) run_job(vecs[j], j * 40);

    // Reset in the middle of a Len=5 job after two triples
    @(posedge clk);
    #1;
    rnd_w = 0; rnd_i = 0; rnd_o = 0;
    clear_stats();
    Len = 8'd5;
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    feed(2, 200);
    check("mid_job_busy", int'(Busy), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_busy", int'(Busy), 0);
    check("mid_rst_done", int'(Done), 0);
    check("mid_rst_valids", int'({bus.W_DataOutValid, bus.I_DataOutValid, bus.O_NOPOut}), 0);
    check("mid_rst_host_rdy", int'(bus.Host_DataInRdy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_w.delete();
    q_i.delete();
    q_o.delete();
    run_job(vecs[7], 230);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 SHALL have parameter DataInWidth, default 8, width of W, I and O operands.
REQ-002 SHALL have parameter BufferWidth, default 2, buffer index width.
REQ-003 SHALL have parameter BufferSize, default 4, buffer entries (2**BufferWidth).
REQ-004 SHALL have parameter LenWidth, default 8, job length width.
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 reset. One clock; reset is synchronous and active-high.
REQ-006 SHALL have ports: Start in 1 job start; Len in LenWidth triples per job; Busy out 1 job active; Done out 1 one-cycle completion pulse.
REQ-007 SHALL have ports: Host_DataInValid in 1; Host_DataInRdy out 1; Host_W, Host_I, Host_O in DataInWidth each, one operand triple.
REQ-008 SHALL have ports: W_DataOut out DataInWidth; W_DataOutValid out 1; W_DataOutRdy in 1.
REQ-009 SHALL have ports: I_DataOut out DataInWidth; I_DataOutValid out 1; I_DataOutRdy in 1.
REQ-010 SHALL have ports: O_DataOut out DataInWidth, partial-sum seed; O_NOPOut out 1, O valid; O_DataOutRdy in 1.

Function
REQ-011 SHALL implement FSM IDLE, RUN, DONE.
REQ-012 IDLE: Start=1 with Len>0 SHALL latch Len and go to RUN; Len=0 SHALL go to DONE; Start outside IDLE ignored.
REQ-013 Busy SHALL be 1 in RUN only; Done SHALL be 1 only in DONE, which lasts one cycle, then IDLE.
REQ-014 Host_DataInRdy SHALL be RUN && !full && accepted<Len, from registered state only (no same-cycle pop credit).
REQ-015 Host handshake SHALL write the triple at tail pointer; tail SHALL be BufferWidth+1 bits (round bit), wrapping modulo 2*BufferSize.
REQ-016 Each of W, I, O channels SHALL own an independent head pointer (BufferWidth+1 bits); channel valid = head != tail; data = buffer[head]; head advances on valid&&rdy.
REQ-017 Entry SHALL be freed only when all three heads have passed it; full = tail minus slowest head equals BufferSize.
REQ-018 Triple accepted in cycle t SHALL show valid on all idle channels in cycle t+1.
REQ-019 Once a channel valid is 1, its data and valid SHALL hold until handshake.
REQ-020 Channels SHALL progress independently; a stalled channel SHALL not block others until buffer full.
REQ-021 RUN SHALL exit to DONE the cycle after all three channels have each sent Len items.
REQ-022 Outside RUN all valids and Host_DataInRdy SHALL be 0.

Reset
REQ-023 rst SHALL clear all pointers and counters, set FSM IDLE, drive Busy, Done, all valids, Host_DataInRdy to 0 in the next cycle, including mid-job; buffer contents need no reset.

Configuration
REQ-024 With FEEDER_STATS_EN defined, SHALL add output Stall_Count 16 bits: cycles in RUN with any channel valid&&!rdy, saturating at 16'hFFFF, cleared on accepted Start.
REQ-025 Without FEEDER_STATS_EN, port and counter SHALL be absent; other behaviour identical.

Structure
REQ-026 Shared package pe_pkg SHALL hold DataInWidth, BufferWidth, BufferSize defaults and the FSM state typedef.
REQ-027 Per-channel head pointer and valid logic SHALL be sub-module feeder_channel, instantiated three times.

Verification
REQ-028 Len=3, all rdy=1, triples (1,2,3),(4,5,6),(7,8,9) -> each channel emits them in order, one per cycle, first valid one cycle after first host handshake; Done pulses once.
REQ-029 Len=6, W_DataOutRdy=0 for 10 cycles -> I, O deliver 4 items, Host_DataInRdy drops after 4 accepts; releasing W drains all 6, Done once.
REQ-030 Len=0 Start -> Done pulse next cycle, no valid ever asserted.
REQ-031 Len=8 with random rdy per channel -> pointers wrap twice, each channel sequence matches host order, no loss/duplication.
REQ-032 rst asserted mid-job after 2 of 5 items -> next cycle all valids 0, FSM IDLE; new Start Len=1 completes normally.
REQ-033 FEEDER_STATS_EN, Len=2, O_DataOutRdy=0 for 5 cycles with O valid -> Stall_Count=5.
